exception_sequencer: RTL

Sequences entry into and exit from the exception handler by driving the write ports of the CP0 register file (Cause, Status, EPC) and the PC-redirect path of the fetch stage. It sits beside CP0 and takes in external interrupt lines, synchronous exception requests from decode/execute, and eret. It produces CP0 write strobes and data, a pipeline flush, and a PC redirect. It accepts one event at a time and is busy until the redirect has been issued.

---
 rtl/exception_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/exception_sequencer.sv
// CP0 exception/interrupt entry and eret exit sequencer. It drives the Cause/Status/EPC
// write ports, the pipeline flush, and the fetch redirect. It handles one event at a time.
module exception_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_F000,
  parameter int          IRQ_WIDTH    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [IRQ_WIDTH-1:0] i_irq,
  input  logic                 i_overflow_req,
  input  logic                 i_syscall_req,
  input  logic                 i_break_req,
  input  logic                 i_reserved_req,
  input  logic                 i_eret_req,
  input  logic [31:0]          i_exc_pc,
  input  logic [31:0]          i_next_pc,
  input  logic [31:0]          i_status_rd,
  input  logic [31:0]          i_cause_rd,
  input  logic [31:0]          i_epc_rd,
  output logic                 o_status_we,
  output logic                 o_cause_we,
  output logic                 o_epc_we,
  output logic [31:0]          o_status_wd,
  output logic [31:0]          o_cause_wd,
  output logic [31:0]          o_epc_wd,
  output logic                 o_flush,
  output logic                 o_redirect,
  output logic [31:0]          o_redirect_pc,
  output logic                 o_busy
);

  typedef enum logic [1:0] {IDLE, SAVE, JUMP, RESTORE} state_t;

  state_t      r_state, w_next;
  logic        w_exc_any, w_int_pending, w_take_entry, w_take_eret;
  logic [4:0]  w_exc_code;
  logic [31:0] w_cause_entry, w_status_entry;

  logic        r_status_we, r_cause_we, r_epc_we, r_flush, r_redirect, r_busy;
  logic [31:0] r_status_wd, r_cause_wd, r_epc_wd, r_redirect_pc;

  assign w_exc_any     = i_overflow_req | i_syscall_req | i_break_req | i_reserved_req;
  assign w_int_pending = i_status_rd[0] & (|(i_irq & i_status_rd[10 +: IRQ_WIDTH]));
  assign w_take_entry  = (r_state == IDLE) && (w_exc_any || w_int_pending);
  assign w_take_eret   = (r_state == IDLE) && !(w_exc_any || w_int_pending) && i_eret_req;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_exc_code = 5'b00000;
    if (i_overflow_req)      w_exc_code = 5'b01100;
    else if (i_syscall_req)  w_exc_code = 5'b01000;
    else if (i_break_req)    w_exc_code = 5'b01001;
    else if (i_reserved_req) w_exc_code = 5'b01010;

    w_cause_entry                   = i_cause_rd;
    w_cause_entry[6:2]              = w_exc_code;
    w_cause_entry[10 +: IRQ_WIDTH]  = i_irq & i_status_rd[10 +: IRQ_WIDTH];

    w_status_entry      = i_status_rd;
    w_status_entry[0]   = 1'b0;
    w_status_entry[4:3] = 2'b00;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_take_entry)     w_next = SAVE;
        else if (w_take_eret) w_next = RESTORE;
      end
      SAVE:    w_next = JUMP;
      JUMP:    w_next = IDLE;
      RESTORE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  // NOTE: the write-data registers are reset too, because every output must read 0 after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_status_we   <= 1'b0;
      r_cause_we    <= 1'b0;
      r_epc_we      <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_busy        <= 1'b0;
      r_status_wd   <= '0;
      r_cause_wd    <= '0;
      r_epc_wd      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_status_we <= (w_next == SAVE) || (w_next == RESTORE);
      r_cause_we  <= (w_next == SAVE);
      r_epc_we    <= (w_next == SAVE);
      r_flush     <= (w_next != IDLE);
      r_redirect  <= (w_next == JUMP) || (w_next == RESTORE);
      r_busy      <= (w_next != IDLE);
      if (w_take_entry) begin
        r_cause_wd    <= w_cause_entry;
        r_status_wd   <= w_status_entry;
        r_epc_wd      <= w_exc_any ? i_exc_pc : i_next_pc;
        r_redirect_pc <= HANDLER_ADDR;
      end else if (w_take_eret) begin
        r_status_wd   <= i_status_rd | 32'h0000_0001;
        r_redirect_pc <= i_epc_rd;
      end
    end
  end

  assign o_status_we   = r_status_we;
  assign o_cause_we    = r_cause_we;
  assign o_epc_we      = r_epc_we;
  assign o_status_wd   = r_status_wd;
  assign o_cause_wd    = r_cause_wd;
  assign o_epc_wd      = r_epc_wd;
  assign o_flush       = r_flush;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_busy        = r_busy;

endmodule
